helix_pb_spi: RTL and testbench

//  Port-mapped SPI master hanging directly off the HELIX setup PicoBlaze port bus
//  (port_id/out_port/strobes) and returning read data on in_port. Lets setup firmware

---
 rtl/helix_pb_pkg.sv | 26 ++
 rtl/helix_spi_shifter.sv | 113 +++++++++++
 rtl/helix_pb_spi.sv | 132 +++++++++++++
 tb/tb_helix_pb_spi.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/helix_pb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | helix_pb_pkg                                                         |
// | Shared register offsets, shifter states and STATUS bit positions     |
// | for the PicoBlaze-attached SPI master.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package helix_pb_pkg;

   localparam logic [1:0] OFF_TX   = 2'd0;
   localparam logic [1:0] OFF_RX   = 2'd1;
   localparam logic [1:0] OFF_STAT = 2'd2;
   localparam logic [1:0] OFF_CS   = 2'd3;

   typedef logic [1:0] spi_state_t;
   localparam spi_state_t ST_IDLE     = 2'd0;
   localparam spi_state_t ST_SHIFT_LO = 2'd1;
   localparam spi_state_t ST_SHIFT_HI = 2'd2;
   localparam spi_state_t ST_FINISH   = 2'd3;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVR  = 2;

endpackage
`default_nettype wire

// File: rtl/helix_spi_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | helix_spi_shifter                                                    |
// | Mode-0 8-bit SPI shift engine: SCLK divider, bit FSM, shift register |
// | and two-flop MISO synchroniser.                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module helix_spi_shifter
   import helix_pb_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start,
   input  logic [7:0] tx,
   input  logic       miso_i,
   output logic [7:0] rx,
   output logic       busy,
   output logic       done,
   output logic       sclk_o,
   output logic       mosi_o
);

   localparam logic [7:0] C_DIV_RELOAD = 8'(CLK_DIV - 1);

   spi_state_t r_state;
   logic [7:0] r_div;
   logic [2:0] r_bitcnt;
   logic [7:0] r_shreg;
   logic [1:0] r_miso_sync;
   logic       r_sample;
   logic [7:0] r_rx;
   logic       r_busy;
   logic       r_sclk;
   logic       r_mosi;
   logic       w_div_end;

   assign w_div_end = (r_div == 8'd0);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_miso_sync <= 2'b00;
      end else begin
         r_miso_sync <= {r_miso_sync[0], miso_i};
      end
   end

   // The divider reloads on every state change, so each half-period is exactly CLK_DIV cycles.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= ST_IDLE;
         r_div    <= C_DIV_RELOAD;
         r_bitcnt <= 3'd0;
         r_shreg  <= 8'h00;
         r_sample <= 1'b0;
         r_rx     <= 8'h00;
         r_busy   <= 1'b0;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_shreg  <= tx;
                  r_mosi   <= tx[7];
                  r_busy   <= 1'b1;
                  r_bitcnt <= 3'd0;
                  r_div    <= C_DIV_RELOAD;
                  r_state  <= ST_SHIFT_LO;
               end
            end
            ST_SHIFT_LO: begin
               if (w_div_end) begin
                  r_sclk   <= 1'b1;
                  r_sample <= r_miso_sync[1];
                  r_div    <= C_DIV_RELOAD;
                  r_state  <= ST_SHIFT_HI;
               end else begin
                  r_div <= r_div - 8'd1;
               end
            end
            ST_SHIFT_HI: begin
               if (w_div_end) begin
                  r_sclk   <= 1'b0;
                  r_shreg  <= {r_shreg[6:0], r_sample};
                  r_mosi   <= r_shreg[6];
                  r_bitcnt <= r_bitcnt + 3'd1;
                  r_div    <= C_DIV_RELOAD;
                  r_state  <= (r_bitcnt == 3'd7) ? ST_FINISH : ST_SHIFT_LO;
               end else begin
                  r_div <= r_div - 8'd1;
               end
            end
            ST_FINISH: begin
               r_rx    <= r_shreg;
               r_busy  <= 1'b0;
               r_div   <= C_DIV_RELOAD;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rx     = r_rx;
   assign busy   = r_busy;
   assign done   = (r_state == ST_FINISH);
   assign sclk_o = r_sclk;
   assign mosi_o = r_mosi;

endmodule
`default_nettype wire

// File: rtl/helix_pb_spi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | helix_pb_spi                                                         |
// | PicoBlaze port-mapped SPI master: address decode, CS register,       |
// | sticky flags and registered in_port read mux.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module helix_pb_spi
   import helix_pb_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'h00,
   parameter int         CLK_DIV   = 4,
   parameter int         NUM_CS    = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [7:0]        port_id,
   input  logic [7:0]        out_port,
   input  logic              write_strobe,
   input  logic              k_write_strobe,
   input  logic              read_strobe,
   output logic [7:0]        in_port,
   output logic              sclk_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic [NUM_CS-1:0] cs_n_o
);

   localparam logic [7:0] C_CS_MASK = 8'((1 << NUM_CS) - 1);

   logic       w_sel;
   logic [1:0] w_off;
   logic       w_tx_req;
   logic       w_cs_req;
   logic       w_rd_rx;
   logic       w_rd_stat;
   logic       w_start;
   logic       w_ovr_set;
   logic       w_busy;
   logic       w_done_pulse;
   logic [7:0] w_rx;
   logic [7:0] w_status;
   logic [7:0] w_rd_data;

   logic [7:0] r_cs;
   logic       r_done;
   logic       r_ovr;
   logic [7:0] r_in_port;

   assign w_sel = (port_id[7:2] == BASE_ADDR[7:2]);
   assign w_off = port_id[1:0];

   // OUTPUTK sees only port_id[3:0]; a coincident OUTPUT strobe takes priority.
   assign w_tx_req = (write_strobe && w_sel && (w_off == OFF_TX))
                  || (k_write_strobe && !write_strobe
                      && (port_id[3:2] == BASE_ADDR[3:2]) && (w_off == OFF_TX));
   assign w_cs_req  = write_strobe && w_sel && (w_off == OFF_CS);
   assign w_rd_rx   = read_strobe && w_sel && (w_off == OFF_RX);
   assign w_rd_stat = read_strobe && w_sel && (w_off == OFF_STAT);
   assign w_start   = w_tx_req && !w_busy;
   assign w_ovr_set = (w_tx_req || w_cs_req) && w_busy;

   helix_spi_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .start   (w_start),
      .tx      (out_port),
      .miso_i  (miso_i),
      .rx      (w_rx),
      .busy    (w_busy),
      .done    (w_done_pulse),
      .sclk_o  (sclk_o),
      .mosi_o  (mosi_o)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cs   <= 8'hFF;
         r_done <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         if (w_cs_req && !w_busy) begin
            r_cs <= out_port;
         end
         // Setting always beats clear-on-read.
         if (w_done_pulse) begin
            r_done <= 1'b1;
         end else if (w_start || w_rd_rx) begin
            r_done <= 1'b0;
         end
         if (w_ovr_set) begin
            r_ovr <= 1'b1;
         end else if (w_rd_stat) begin
            r_ovr <= 1'b0;
         end
      end
   end

   always_comb begin
      w_status            = 8'h00;
      w_status[STAT_BUSY] = w_busy;
      w_status[STAT_DONE] = r_done;
      w_status[STAT_OVR]  = r_ovr;
   end

   always_comb begin
      w_rd_data = 8'h00;
      if (w_sel) begin
         case (w_off)
            OFF_RX:   w_rd_data = w_rx;
            OFF_STAT: w_rd_data = w_status;
            OFF_CS:   w_rd_data = r_cs & C_CS_MASK;
            default:  w_rd_data = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_in_port <= 8'h00;
      end else begin
         r_in_port <= w_rd_data;
      end
   end

   assign in_port = r_in_port;
   assign cs_n_o  = r_cs[NUM_CS-1:0];

endmodule
`default_nettype wire

// File: tb/tb_helix_pb_spi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_helix_pb_spi                                                      |
// | Directed bench with a cycle-timing reference model of the SPI block. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_helix_pb_spi;

   localparam int         D     = 4;
   localparam int         NCS   = 4;
   localparam int         FRAME = 16 * D;
   localparam logic [7:0] P_TX  = 8'h00;
   localparam logic [7:0] P_RX  = 8'h01;
   localparam logic [7:0] P_ST  = 8'h02;
   localparam logic [7:0] P_CS  = 8'h03;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [7:0]     port_id = 8'h00;
   logic [7:0]     out_port = 8'h00;
   logic           ws = 1'b0;
   logic           kws = 1'b0;
   logic           rs = 1'b0;
   logic [7:0]     in_port;
   logic           sclk;
   logic           mosi;
   logic [NCS-1:0] cs_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // MISO is looped back from MOSI.
   helix_pb_spi #(
      .BASE_ADDR (8'h00),
      .CLK_DIV   (D),
      .NUM_CS    (NCS)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .port_id        (port_id),
      .out_port       (out_port),
      .write_strobe   (ws),
      .k_write_strobe (kws),
      .read_strobe    (rs),
      .in_port        (in_port),
      .sclk_o         (sclk),
      .mosi_o         (mosi),
      .miso_i         (mosi),
      .cs_n_o         (cs_n)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame position k counts cycles since the start strobe;
   // k=1..FRAME are shift cycles, k=FRAME+1 is the finish cycle.
   int         m_k = 0;
   logic [7:0] m_byte = 8'h00;
   logic [7:0] m_rx = 8'h00;
   logic [7:0] m_cs = 8'hFF;
   logic       m_done = 1'b0;
   logic       m_ov = 1'b0;
   logic       e_sclk = 1'b0;
   logic       e_mosi = 1'b0;
   logic       e_mosi_chk = 1'b0;
   logic [7:0] e_in = 8'h00;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_k = 0; m_rx = 8'h00; m_cs = 8'hFF; m_done = 1'b0; m_ov = 1'b0; e_in = 8'h00;
         end else begin
            bit busy_now, fin, sel, txw, csw, rdrx, rdst, start;
            busy_now = (m_k != 0);
            fin      = (m_k == FRAME + 1);
            sel      = (port_id[7:2] == 6'd0);
            txw      = (ws && sel && port_id[1:0] == 2'd0) || (kws && !ws && port_id[3:0] == 4'd0);
            csw      = ws && sel && port_id[1:0] == 2'd3;
            rdrx     = rs && sel && port_id[1:0] == 2'd1;
            rdst     = rs && sel && port_id[1:0] == 2'd2;
            start    = txw && !busy_now;
            if (!sel)                       e_in = 8'h00;
            else if (port_id[1:0] == 2'd1)  e_in = m_rx;
            else if (port_id[1:0] == 2'd2)  e_in = {5'd0, m_ov, m_done, busy_now};
            else if (port_id[1:0] == 2'd3)  e_in = {4'd0, m_cs[3:0]};
            else                            e_in = 8'h00;
            if (fin) m_rx = m_byte;
            if (csw && !busy_now) m_cs = out_port;
            if ((txw || csw) && busy_now) m_ov = 1'b1;
            else if (rdst)                m_ov = 1'b0;
            if (fin)                  m_done = 1'b1;
            else if (start || rdrx)   m_done = 1'b0;
            if (start) begin
               m_k = 1; m_byte = out_port;
            end else if (fin) begin
               m_k = 0;
            end else if (busy_now) begin
               m_k = m_k + 1;
            end
         end
         e_mosi_chk = (m_k >= 1 && m_k <= FRAME);
         e_sclk     = e_mosi_chk && (((m_k - 1) / D) % 2 == 1);
         e_mosi     = 1'b0;
         if (e_mosi_chk) e_mosi = m_byte[7 - ((m_k - 1) / (2 * D))];
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         check("cycle {sclk,cs_n,in_port,mosi}",
               {18'd0, sclk, cs_n, in_port, (e_mosi_chk ? mosi : 1'b0)},
               {18'd0, e_sclk, m_cs[3:0], e_in, e_mosi});
      end
   end

   logic [7:0] cap = 8'h00;
   initial begin
      forever begin
         @(posedge sclk);
         cap = {cap[6:0], mosi};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic wr(input logic [7:0] p, input logic [7:0] d);
      port_id = p; out_port = d; ws = 1'b1;
      @(negedge clk);
      ws = 1'b0;
   endtask

   task automatic kwr(input logic [7:0] p, input logic [7:0] d);
      port_id = p; out_port = d; kws = 1'b1;
      @(negedge clk);
      kws = 1'b0;
   endtask

   task automatic rd(input logic [7:0] p, output logic [7:0] d);
      port_id = p;
      @(negedge clk);
      rs = 1'b1;
      d  = in_port;
      @(negedge clk);
      rs = 1'b0;
   endtask

   logic [7:0] d;

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset cs_n", {28'd0, cs_n}, 32'hF);
      check("reset sclk", {31'd0, sclk}, 32'h0);
      check("reset mosi", {31'd0, mosi}, 32'h0);
      check("reset in_port", {24'd0, in_port}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      rd(P_ST, d); check("reset status", {24'd0, d}, 32'h00);

      // Reset in the middle of a frame
      wr(P_CS, 8'hF6);
      wr(P_TX, 8'hC3);
      repeat (21) @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("midreset cs_n", {28'd0, cs_n}, 32'hF);
      check("midreset sclk", {31'd0, sclk}, 32'h0);
      check("midreset mosi", {31'd0, mosi}, 32'h0);
      check("midreset in_port", {24'd0, in_port}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      rd(P_ST, d); check("midreset status", {24'd0, d}, 32'h00);
      rd(P_CS, d); check("midreset cs read", {24'd0, d}, 32'h0F);

      // Basic loopback frame and busy window
      wr(P_TX, 8'hA5);
      repeat (64) @(negedge clk);
      rd(P_ST, d); check("busy at t+65", {24'd0, d}, 32'h01);
      check("done at t+66", {24'd0, in_port}, 32'h02);
      check("mosi bit stream", {24'd0, cap}, 32'hA5);
      rd(P_ST, d); check("status before rx", {24'd0, d}, 32'h02);
      rd(P_RX, d); check("rx A5", {24'd0, d}, 32'hA5);
      rd(P_ST, d); check("status after rx", {24'd0, d}, 32'h00);

      // Writes while busy are dropped and flag overrun
      wr(P_TX, 8'h81);
      repeat (3) @(negedge clk);
      wr(P_TX, 8'hFF);
      wr(P_CS, 8'h00);
      rd(P_ST, d); check("overrun status", {24'd0, d}, 32'h05);
      rd(P_ST, d); check("overrun cleared", {24'd0, d}, 32'h01);
      check("cs unchanged", {28'd0, cs_n}, 32'hF);
      repeat (70) @(negedge clk);
      rd(P_RX, d); check("rx 81 unchanged", {24'd0, d}, 32'h81);
      check("mosi bit stream 81", {24'd0, cap}, 32'h81);
      rd(P_ST, d); check("status idle", {24'd0, d}, 32'h00);

      // RX read lands in the finish cycle with an overrun pending
      wr(P_TX, 8'h5A);
      wr(P_TX, 8'h00);
      repeat (62) @(negedge clk);
      rd(P_RX, d); check("rx in finish", {24'd0, d}, 32'h81);
      rd(P_ST, d); check("done+ovr kept", {24'd0, d}, 32'h06);
      rd(P_ST, d); check("ovr cleared", {24'd0, d}, 32'h02);
      rd(P_RX, d); check("rx 5A", {24'd0, d}, 32'h5A);

      // OUTPUTK decode and write-strobe priority
      kwr(8'h01, 8'h77);
      rd(P_ST, d); check("k to 1 ignored", {24'd0, d}, 32'h00);
      port_id = 8'h10; out_port = 8'h99; ws = 1'b1; kws = 1'b1;
      @(negedge clk);
      ws = 1'b0; kws = 1'b0;
      rd(P_ST, d); check("ws beats kws", {24'd0, d}, 32'h00);
      kwr(8'h00, 8'h3C);
      rd(P_ST, d); check("k tx busy", {24'd0, d}, 32'h01);
      repeat (70) @(negedge clk);
      rd(P_RX, d); check("rx 3C", {24'd0, d}, 32'h3C);

      // Chip selects and undecoded reads
      wr(P_CS, 8'hFE);
      check("cs_n E", {28'd0, cs_n}, 32'hE);
      rd(P_CS, d); check("cs read", {24'd0, d}, 32'h0E);
      rd(8'h40, d); check("undecoded read", {24'd0, d}, 32'h00);
      rd(P_TX, d); check("tx write-only", {24'd0, d}, 32'h00);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
